// File: rtl/vga_pkg.sv
// Shared definitions for the VGA frame-buffer write path and the display path.
package vga_pkg;

    localparam int IMG_W        = 320;
    localparam int IMG_H        = 240;
    localparam int ADDR_W       = 17;
    localparam int FRAME_PIXELS = IMG_W * IMG_H;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_HI,
        WAIT_LO,
        WRITE,
        DONE
    } fsm_state_t;

    // RGB565 field positions, shared with the display-side RGB565 to RGB444 conversion
    localparam int RGB565_R_MSB = 15;
    localparam int RGB565_R_LSB = 11;
    localparam int RGB565_G_MSB = 10;
    localparam int RGB565_G_LSB = 5;
    localparam int RGB565_B_MSB = 4;
    localparam int RGB565_B_LSB = 0;

    function automatic logic [15:0] rgb565_pack(input logic [4:0] r,
                                                input logic [5:0] g,
                                                input logic [4:0] b);
        logic [15:0] px;
        px = '0;
        px[RGB565_R_MSB:RGB565_R_LSB] = r;
        px[RGB565_G_MSB:RGB565_G_LSB] = g;
        px[RGB565_B_MSB:RGB565_B_LSB] = b;
        return px;
    endfunction

endpackage

// File: rtl/frame_buffer_writer.sv
// Assembles big-endian byte pairs into RGB565 pixels and writes them in raster
// order into the frame-buffer RAM read by the VGA display path.
module frame_buffer_writer #(
    parameter int IMG_W  = vga_pkg::IMG_W,
    parameter int IMG_H  = vga_pkg::IMG_H,
    parameter int ADDR_W = vga_pkg::ADDR_W
) (
    input  logic              clk_50mhz,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [15:0]       ram_wdata,
    output logic              busy,
    output logic              done
);

    import vga_pkg::*;

    localparam logic [ADDR_W-1:0] LAST_PIXEL = ADDR_W'(IMG_W * IMG_H - 1);

    fsm_state_t        state;
    fsm_state_t        next_state;
    logic [ADDR_W-1:0] pixel_count;
    logic [7:0]        pixel_hi;
    logic [7:0]        pixel_lo;
    logic              is_busy;
    logic              abort_now;
    logic              take_byte;

    assign is_busy   = (state == WAIT_HI) || (state == WAIT_LO) || (state == WRITE);
    assign abort_now = abort && is_busy;
    assign take_byte = in_valid && ((state == WAIT_HI) || (state == WAIT_LO));

    always_ff @(posedge clk_50mhz or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Abort takes priority over everything, including a simultaneous start
    always_comb begin
        next_state = state;
        if (abort_now) begin
            next_state = IDLE;
        end else begin
            case (state)
                IDLE, DONE: if (start && !abort) next_state = WAIT_HI;
                WAIT_HI:    if (in_valid) next_state = WAIT_LO;
                WAIT_LO:    if (in_valid) next_state = WRITE;
                WRITE:      next_state = (pixel_count == LAST_PIXEL) ? DONE : WAIT_HI;
                default:    next_state = IDLE;
            endcase
        end
    end

    always_comb begin
        in_ready = (state == WAIT_HI) || (state == WAIT_LO);
        ram_we   = (state == WRITE);
        busy     = is_busy;
        done     = (state == DONE);
    end

    // The counter holds at the last pixel so it never wraps into address 0
    always_ff @(posedge clk_50mhz or posedge rst) begin
        if (rst) begin
            pixel_count <= '0;
            pixel_hi    <= '0;
            pixel_lo    <= '0;
        end else if (abort_now) begin
            pixel_count <= '0;
            pixel_hi    <= '0;
            pixel_lo    <= '0;
        end else if ((state == IDLE || state == DONE) && start && !abort) begin
            pixel_count <= '0;
            pixel_hi    <= '0;
            pixel_lo    <= '0;
        end else if (take_byte && state == WAIT_HI) begin
            pixel_hi <= in_data;
        end else if (take_byte && state == WAIT_LO) begin
            pixel_lo <= in_data;
        end else if (state == WRITE && pixel_count != LAST_PIXEL) begin
            pixel_count <= pixel_count + ADDR_W'(1);
        end
    end

    assign ram_addr  = pixel_count;
    assign ram_wdata = {pixel_hi, pixel_lo};

endmodule

// File: tb/tb_frame_buffer_writer.sv
// Directed, table-driven bench for frame_buffer_writer on a 4x2 frame.
module tb_frame_buffer_writer;

    localparam int TW  = 4;
    localparam int TH  = 2;
    localparam int AW  = 17;
    localparam int NPX = TW * TH;

    typedef struct {
        logic [7:0]    hi;
        logic [7:0]    lo;
        logic [AW-1:0] expAddr;
        logic [15:0]   expData;
    } vec_t;

    logic          clk_50mhz = 1'b0;
    logic          rst;
    logic          start;
    logic          abort;
    logic [7:0]    in_data;
    logic          in_valid;
    logic          in_ready;
    logic          ram_we;
    logic [AW-1:0] ram_addr;
    logic [15:0]   ram_wdata;
    logic          busy;
    logic          done;

    int checks   = 0;
    int failures = 0;

    vec_t          frames[2][NPX];
    logic [AW-1:0] wrAddrQ[$];
    logic [15:0]   wrDataQ[$];

    frame_buffer_writer #(.IMG_W(TW), .IMG_H(TH), .ADDR_W(AW)) dut (
        .clk_50mhz(clk_50mhz),
        .rst(rst),
        .start(start),
        .abort(abort),
        .in_data(in_data),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .ram_we(ram_we),
        .ram_addr(ram_addr),
        .ram_wdata(ram_wdata),
        .busy(busy),
        .done(done)
    );

    always #10 clk_50mhz = ~clk_50mhz;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    // Capture every RAM write; in_ready must be low whenever a write is issued
    always @(negedge clk_50mhz) begin
        if (ram_we === 1'b1) begin
            wrAddrQ.push_back(ram_addr);
            wrDataQ.push_back(ram_wdata);
            checkOutput("in_ready_low_in_write", {31'b0, in_ready}, 32'd0);
        end
    end

    // Offer one byte after an optional idle gap and hold it until it is accepted
    task automatic applyStimulus(input logic [7:0] b, input int gap);
        int n;
        in_valid = 1'b0;
        repeat (gap) @(negedge clk_50mhz);
        in_data  = b;
        in_valid = 1'b1;
        n = 0;
        while (in_ready !== 1'b1 && n < 50) begin
            @(negedge clk_50mhz);
            n++;
        end
        if (n >= 50) checkOutput("handshake_timeout", {31'b0, in_ready}, 32'd1);
        @(negedge clk_50mhz);
        in_valid = 1'b0;
    endtask

    task automatic pulseStart();
        start = 1'b1;
        @(negedge clk_50mhz);
        start = 1'b0;
        checkOutput("in_ready_after_start", {31'b0, in_ready}, 32'd1);
    endtask

    task automatic sendPixels(input int f, input int first, input int last, input bit gaps);
        for (int i = first; i <= last; i++) begin
            applyStimulus(frames[f][i].hi, gaps ? int'($urandom_range(0, 3)) : 0);
            applyStimulus(frames[f][i].lo, gaps ? int'($urandom_range(0, 3)) : 0);
        end
    endtask

    task automatic checkWrites(input int f, input int first, input int last);
        int cnt;
        cnt = last - first + 1;
        checkOutput("write_count", wrAddrQ.size(), cnt);
        for (int i = 0; i < cnt && i < wrAddrQ.size(); i++) begin
            checkOutput("write_addr", 32'(wrAddrQ[i]), 32'(frames[f][first + i].expAddr));
            checkOutput("write_data", 32'(wrDataQ[i]), 32'(frames[f][first + i].expData));
        end
    endtask

    task automatic waitDone();
        int n;
        n = 0;
        while (done !== 1'b1 && n < 20) begin
            @(negedge clk_50mhz);
            n++;
        end
        checkOutput("done_reached", {31'b0, done}, 32'd1);
    endtask

    task automatic clearWrites();
        wrAddrQ.delete();
        wrDataQ.delete();
    endtask

    initial begin
        logic [7:0] his[NPX] = '{8'h12, 8'hF8, 8'h07, 8'h00, 8'hFF, 8'h00, 8'hA5, 8'h80};
        logic [7:0] los[NPX] = '{8'h34, 8'h00, 8'hE0, 8'h1F, 8'hFF, 8'h00, 8'h5A, 8'h01};
        for (int i = 0; i < NPX; i++) begin
            frames[0][i] = '{hi: 8'hF8, lo: 8'h00, expAddr: AW'(i), expData: 16'hF800};
            frames[1][i] = '{hi: his[i], lo: los[i], expAddr: AW'(i), expData: {his[i], los[i]}};
        end

        rst = 1'b1; start = 1'b0; abort = 1'b0; in_data = 8'h00; in_valid = 1'b0;
        #1;
        checkOutput("reset_in_ready", {31'b0, in_ready}, 32'd0);
        checkOutput("reset_ram_we", {31'b0, ram_we}, 32'd0);
        checkOutput("reset_ram_addr", 32'(ram_addr), 32'd0);
        checkOutput("reset_ram_wdata", 32'(ram_wdata), 32'd0);
        checkOutput("reset_busy", {31'b0, busy}, 32'd0);
        checkOutput("reset_done", {31'b0, done}, 32'd0);
        repeat (2) @(negedge clk_50mhz);
        rst = 1'b0;
        @(negedge clk_50mhz);

        $display("[TB] nominal frame, in_valid held high");
        clearWrites();
        pulseStart();
        sendPixels(0, 0, NPX - 1, 1'b0);
        checkOutput("last_write_we", {31'b0, ram_we}, 32'd1);
        checkOutput("last_write_addr", 32'(ram_addr), NPX - 1);
        @(negedge clk_50mhz);
        checkOutput("done_after_last", {31'b0, done}, 32'd1);
        checkOutput("busy_after_last", {31'b0, busy}, 32'd0);
        checkWrites(0, 0, NPX - 1);

        $display("[TB] varied pixels with random gaps");
        clearWrites();
        pulseStart();
        checkOutput("done_cleared_by_start", {31'b0, done}, 32'd0);
        sendPixels(1, 0, 0, 1'b0);
        checkOutput("byte_order_data", 32'(ram_wdata), 32'h1234);
        checkOutput("byte_order_addr", 32'(ram_addr), 32'd0);
        sendPixels(1, 1, NPX - 1, 1'b1);
        waitDone();
        checkWrites(1, 0, NPX - 1);

        $display("[TB] reset mid-frame");
        clearWrites();
        pulseStart();
        sendPixels(1, 0, 2, 1'b0);
        applyStimulus(frames[1][3].hi, 0);
        checkOutput("writes_before_reset", wrAddrQ.size(), 3);
        #5 rst = 1'b1;
        #1;
        checkOutput("midreset_in_ready", {31'b0, in_ready}, 32'd0);
        checkOutput("midreset_busy", {31'b0, busy}, 32'd0);
        checkOutput("midreset_addr", 32'(ram_addr), 32'd0);
        checkOutput("midreset_wdata", 32'(ram_wdata), 32'd0);
        @(negedge clk_50mhz);
        rst = 1'b0;
        @(negedge clk_50mhz);
        clearWrites();
        pulseStart();
        sendPixels(1, 0, NPX - 1, 1'b0);
        waitDone();
        checkWrites(1, 0, NPX - 1);

        $display("[TB] abort after high byte of pixel 2");
        clearWrites();
        pulseStart();
        sendPixels(1, 0, 1, 1'b0);
        applyStimulus(frames[1][2].hi, 0);
        abort = 1'b1;
        @(negedge clk_50mhz);
        abort = 1'b0;
        checkOutput("abort_busy", {31'b0, busy}, 32'd0);
        checkOutput("abort_done", {31'b0, done}, 32'd0);
        in_data  = 8'h55;
        in_valid = 1'b1;
        repeat (5) @(negedge clk_50mhz);
        checkOutput("abort_in_ready", {31'b0, in_ready}, 32'd0);
        in_valid = 1'b0;
        checkOutput("abort_no_more_writes", wrAddrQ.size(), 2);
        clearWrites();
        pulseStart();
        sendPixels(1, 0, NPX - 1, 1'b1);
        waitDone();
        checkWrites(1, 0, NPX - 1);

        $display("[TB] abort and start together while busy");
        pulseStart();
        abort = 1'b1;
        start = 1'b1;
        @(negedge clk_50mhz);
        abort = 1'b0;
        start = 1'b0;
        checkOutput("abort_wins_busy", {31'b0, busy}, 32'd0);

        $display("[TB] start ignored while busy");
        clearWrites();
        pulseStart();
        sendPixels(1, 0, 2, 1'b0);
        applyStimulus(frames[1][3].hi, 0);
        start = 1'b1;
        @(negedge clk_50mhz);
        start = 1'b0;
        applyStimulus(frames[1][3].lo, 0);
        sendPixels(1, 4, NPX - 1, 1'b0);
        waitDone();
        checkWrites(1, 0, NPX - 1);

        $display("[TB] start from DONE");
        clearWrites();
        pulseStart();
        checkOutput("done_clear_from_done", {31'b0, done}, 32'd0);
        sendPixels(1, 0, 0, 1'b0);
        @(negedge clk_50mhz);
        checkWrites(1, 0, 0);
        abort = 1'b1;
        @(negedge clk_50mhz);
        abort = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/frame_buffer_writer.md
# frame_buffer_writer

Write-side counterpart to the VGA display path. Accepts an 8-bit byte stream (UART receiver or test loader) through a valid/ready handshake, assembles byte pairs into RGB565 pixels, and writes them in raster order into the 17-bit-addressed frame-buffer RAM that the VGA block reads. Reports progress and frame completion to the top-level control logic.

## Interface
Parameters:
- IMG_W, 320, image width in pixels
- IMG_H, 240, image height in pixels
- ADDR_W, 17, RAM address width; IMG_W*IMG_H must be ≤ 2^ADDR_W

Ports:
- clk_50mhz  input  1  system clock, 50 MHz
- rst  input  1  asynchronous, active-high reset
- start  input  1  one-cycle pulse: begin loading a new frame at address 0
- abort  input  1  one-cycle pulse: stop the current frame immediately
- in_data  input  8  stream byte
- in_valid  input  1  in_data valid
- in_ready  output  1  block can accept a byte this cycle
- ram_we  output  1  RAM write strobe, one cycle per pixel
- ram_addr  output  ADDR_W  write address
- ram_wdata  output  16  RGB565 pixel {R[4:0],G[5:0],B[4:0]}
- busy  output  1  a frame load is in progress
- done  output  1  last frame completed; held until the next start

## Operation
- States: IDLE, WAIT_HI, WAIT_LO, WRITE, DONE.
- IDLE/DONE: in_ready=0. A start pulse clears the pixel counter to 0, clears done, and moves to WAIT_HI.
- WAIT_HI: in_ready=1. A handshake (in_valid&&in_ready) latches in_data as pixel[15:8] and moves to WAIT_LO.
- WAIT_LO: in_ready=1. A handshake latches pixel[7:0] and moves to WRITE. Byte order is big-endian: high byte first.
- WRITE: in_ready=0; ram_we=1; ram_addr=counter; ram_wdata=assembled pixel. On the next edge:
  - If counter==IMG_W*IMG_H-1, go to DONE with done=1.
  - Otherwise increment counter and return to WAIT_HI.
- busy=1 in WAIT_HI, WAIT_LO and WRITE.
- start while busy is ignored.
- abort in any busy state returns to IDLE, clears the counter, and drops any half-assembled pixel. No further writes occur; done stays 0. If abort and start are asserted in the same cycle, abort wins.
- in_data is ignored whenever in_ready=0. Bytes offered then are not consumed, and the source must hold them.
- The counter never wraps. A frame ends exactly at the last pixel.

## Timing
- Reset values: in_ready=0, ram_we=0, ram_addr=0, ram_wdata=0, busy=0, done=0, state IDLE, counter 0.
- Outputs are registered or decoded from state only. There is no combinational path from in_valid to in_ready.
- in_ready rises the cycle after start is sampled.
- Write latency: ram_we is asserted the cycle after the low-byte handshake.
- Peak throughput is one pixel per 3 cycles (HI, LO, WRITE).
- ram_addr and ram_wdata are stable for the whole cycle in which ram_we=1. The RAM captures them on the same rising edge that ends that cycle.
- done rises the cycle after the final WRITE cycle.
- Reset asserted mid-frame forces all outputs to reset values asynchronously. Any partially written frame remains in RAM.
- A RAM read port on the VGA clock may observe a mix of old and new pixels during a load. Tearing is accepted.

## Structure
- Shared package vga_pkg holds:
  - IMG_W, IMG_H, ADDR_W and the derived FRAME_PIXELS constant.
  - The fsm_state_t enum.
  - The RGB565 field-position constants, also used by the display path's RGB565→RGB444 conversion.
- Single flat module. There is no natural sub-module; byte assembly is two registers.

## Test plan
- Reset mid-frame: rst asserted after 3 pixels written → all outputs 0 immediately; the next start writes from address 0.
- Nominal 4×2 frame (IMG_W=4, IMG_H=2): start, then bytes 0xF8,0x00 repeated 8 times with in_valid held high → ram_we pulses 8 times at addresses 0..7 with ram_wdata=16'hF800. done=1 one cycle after the pulse at address 7, and busy drops to 0.
- Backpressure/gaps: in_valid toggled randomly, same frame → same 8 writes with identical addresses and data. No write occurs without two handshakes. in_ready=0 during every WRITE cycle.
- Byte order: bytes 0x12,0x34 → single write ram_wdata=16'h1234 at address 0.
- Abort: abort after the high byte of pixel 2 → no further ram_we; state IDLE, done=0. A following start plus 16 bytes writes addresses 0..7 from scratch.
- Start ignored while busy: start pulsed mid-frame → addresses continue in sequence with no restart. start in DONE → done clears and the next write lands at address 0.
